serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: time-shares one 1-bit full-adder cell across a WIDTH-bit add.

---
 rtl/serial_add_pkg.sv | 20 ++
 rtl/fa_bit_cell.sv | 19 +
 rtl/serial_add_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e      : controller FSM state (IDLE/RUN/DONE), 2-bit encoding
//   DefaultWidth : default operand/sum width
//   cnt_width()  : bit-counter width for a given operand width (at least 1 bit)
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width of the bit-position counter; it only has to reach width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// 1-bit combinational full adder, the single arithmetic cell that the serial
// adder time-shares across all bit positions.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. Latches A, B and carry-in on an accepted start,
// feeds one full-adder cell LSB-first (one bit per clock, registered carry) and
// returns the assembled sum and carry-out together with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf_out.
// Parameters:
//   WIDTH    : operand/sum width, 2..32
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request, accepted only while ready=1
//   a_in     : operand A, sampled at accept
//   b_in     : operand B, sampled at accept
//   cin_in   : carry-in, sampled at accept
//   ready    : 1 while idle and able to accept start
//   done     : one-cycle pulse, results valid
//   sum_out  : registered sum, held until the next completion
//   cout_out : registered carry-out, held until the next completion
//   ovf_out  : registered signed overflow (SERIAL_ADD_OVF_EN only)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_s;
  logic cell_cout;

  fa_bit_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    ready   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          s_sr_d  = '0;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        s_sr_d  = {cell_s, s_sr_q[WIDTH-1:1]};
        carry_d = cell_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Capture the fully assembled word directly, including this edge's MSB.
          sum_d   = {cell_s, s_sr_q[WIDTH-1:1]};
          cout_d  = cell_cout;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this last bit.
          ovf_d   = carry_q ^ cell_cout;
`endif
          cnt_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: an 8-bit instance for the directed table,
// random, ignored-start and mid-run reset cases, and a 2-bit instance swept exhaustively.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, ready8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, ready2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf2;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  int done_cnt2 = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a_in     (a8),
    .b_in     (b8),
    .cin_in   (cin8),
    .ready    (ready8),
    .done     (done8),
    .sum_out  (sum8),
    .cout_out (cout8)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_out  (ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .a_in     (a2),
    .b_in     (b2),
    .cin_in   (cin2),
    .ready    (ready2),
    .done     (done2),
    .sum_out  (sum2),
    .cout_out (cout2)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf_out  (ovf2)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; count done pulses and check ready/done exclusivity.
  task automatic step();
    @(negedge clk);
    if (done8) done_cnt8++;
    if (done2) done_cnt2++;
    if (rst_n) begin
      check("ready_done_excl8", {31'd0, ready8 & done8}, 32'd0);
      check("ready_done_excl2", {31'd0, ready2 & done2}, 32'd0);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin; signed overflow when same-sign operands give
  // a result of the other sign.
  function automatic logic ovf_ref(input int unsigned w, input int unsigned a,
                                   input int unsigned b, input int unsigned s);
    logic sa, sb, ss;
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    return (sa == sb) && (ss != sa);
  endfunction

  // lat = rising edges after the accept edge until done is seen (WIDTH expected).
  // inj >= 0 drives a competing start with different operands during that RUN cycle.
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input int inj, output logic [7:0] s, output logic co,
                          output int lat, output logic found);
    int w = 0;
    while (!ready8 && w < 50) begin
      step();
      w++;
    end
    check("ready8_before_start", {31'd0, ready8}, 32'd1);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      if (lat == inj) begin
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      step();
      lat++;
    end
    start8 = 1'b0;
    s = sum8; co = cout8; found = done8;
  endtask

  task automatic run_add2(input logic [1:0] a, input logic [1:0] b, input logic c,
                          output logic [1:0] s, output logic co,
                          output int lat, output logic found);
    int w = 0;
    while (!ready2 && w < 50) begin
      step();
      w++;
    end
    check("ready2_before_start", {31'd0, ready2}, 32'd1);
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    step();
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 40) begin
      step();
      lat++;
    end
    s = sum2; co = cout2; found = done2;
  endtask

  initial begin
    logic [7:0]  s8;
    logic [1:0]  s2;
    logic        co, found;
    int          lat, d0;
    logic [8:0]  full8;
    logic [2:0]  full2;
    logic [7:0]  ra, rb;
    logic        rc;

    vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sum: 8'h96, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) step();

    check("rst_ready8", {31'd0, ready8}, 32'd1);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
    check("rst_ready2", {31'd0, ready2}, 32'd1);
    check("rst_sum2", {30'd0, sum2}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_add8(vecs[i].a, vecs[i].b, vecs[i].cin, -1, s8, co, lat, found);
      check("tbl_done", {31'd0, found}, 32'd1);
      check("tbl_latency", lat, 32'd8);
      check("tbl_sum", {24'd0, s8}, {24'd0, vecs[i].sum});
      check("tbl_cout", {31'd0, co}, {31'd0, vecs[i].cout});
`ifdef SERIAL_ADD_OVF_EN
      check("tbl_ovf", {31'd0, ovf8}, {31'd0, vecs[i].ovf});
`endif
    end

    // Results hold after done
    repeat (3) step();
    check("hold_sum", {24'd0, sum8}, {24'd0, vecs[5].sum});
    check("hold_cout", {31'd0, cout8}, {31'd0, vecs[5].cout});

    // Random against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      full8 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_add8(ra, rb, rc, -1, s8, co, lat, found);
      check("rnd_done", {31'd0, found}, 32'd1);
      check("rnd_latency", lat, 32'd8);
      check("rnd_sum", {24'd0, s8}, {24'd0, full8[7:0]});
      check("rnd_cout", {31'd0, co}, {31'd0, full8[8]});
`ifdef SERIAL_ADD_OVF_EN
      check("rnd_ovf", {31'd0, ovf8},
            {31'd0, ovf_ref(8, 32'(ra), 32'(rb), 32'(full8[7:0]))});
`endif
    end

    // Start during RUN is ignored and not queued
    d0 = done_cnt8;
    run_add8(8'h10, 8'h01, 1'b0, 2, s8, co, lat, found);
    check("ign_done", {31'd0, found}, 32'd1);
    check("ign_latency", lat, 32'd8);
    check("ign_sum", {24'd0, s8}, 32'h11);
    check("ign_cout", {31'd0, co}, 32'd0);
    repeat (12) step();
    check("ign_one_pulse", done_cnt8 - d0, 32'd1);
    check("ign_ready_after", {31'd0, ready8}, 32'd1);

    // Reset in the 4th RUN cycle aborts the add
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (3) step();
    check("abort_running", {31'd0, ready8}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_sum", {24'd0, sum8}, 32'd0);
    check("abort_cout", {31'd0, cout8}, 32'd0);
    check("abort_ready", {31'd0, ready8}, 32'd1);
    check("abort_done", {31'd0, done8}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("abort_ovf", {31'd0, ovf8}, 32'd0);
`endif
    d0 = done_cnt8;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    check("abort_no_done", done_cnt8 - d0, 32'd0);
    run_add8(8'h01, 8'h01, 1'b0, -1, s8, co, lat, found);
    check("post_abort_done", {31'd0, found}, 32'd1);
    check("post_abort_sum", {24'd0, s8}, 32'h02);
    check("post_abort_cout", {31'd0, co}, 32'd0);

    // WIDTH=2 exhaustive sweep
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          full2 = 3'(a + b + c);
          run_add2(2'(a), 2'(b), 1'(c), s2, co, lat, found);
          check("w2_done", {31'd0, found}, 32'd1);
          check("w2_latency", lat, 32'd2);
          check("w2_sum", {30'd0, s2}, {30'd0, full2[1:0]});
          check("w2_cout", {31'd0, co}, {31'd0, full2[2]});
`ifdef SERIAL_ADD_OVF_EN
          check("w2_ovf", {31'd0, ovf2},
                {31'd0, ovf_ref(2, 32'(a), 32'(b), 32'(full2[1:0]))});
`endif
        end
      end
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
